// File: rtl/text_pkg.sv
// Shared character codes and score-line FSM states
// for the HUD text sources.
package text_pkg;
   localparam logic [6:0] CHAR_SPACE = 7'h20;
   localparam logic [6:0] CHAR_ZERO  = 7'h30;

   typedef enum logic [1:0] {
      IDLE,
      CONVERT,
      COMMIT
   } score_state_t;
endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one add-3/shift step per clock,
// SCORE_W steps per conversion.
module bin2bcd_seq #(
   parameter int SCORE_W = 16,
   parameter int DIGITS  = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [SCORE_W-1:0]    bin_in,
   output logic                  busy,
   output logic                  done,
   output logic [DIGITS*4-1:0]   bcd
);
   localparam int CW = (SCORE_W > 1) ? $clog2(SCORE_W) : 1;

   logic [SCORE_W-1:0]  bin_q;
   logic [CW-1:0]       cnt;
   logic [DIGITS*4-1:0] adj;

   always_comb begin
      adj = bcd;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd[4*i +: 4] >= 4'd5)
            adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
   end

   // high during the last shift step
   assign done = busy && (cnt == CW'(SCORE_W-1));

   always_ff @(posedge clk) begin
      if (rst) begin
         busy  <= 1'b0;
         cnt   <= '0;
         bin_q <= '0;
         bcd   <= '0;
      end else if (start && !busy) begin
         busy  <= 1'b1;
         cnt   <= '0;
         bin_q <= bin_in;
         bcd   <= '0;
      end else if (busy) begin
         {bcd, bin_q} <= {adj[DIGITS*4-2:0], bin_q, 1'b0};
         cnt <= cnt + CW'(1);
         if (done)
            busy <= 1'b0;
      end
   end
endmodule

// File: rtl/score_char_buffer.sv
// HUD score line text source: label, converted score digits,
// double-buffered, 1-cycle registered char lookup.
module score_char_buffer
   import text_pkg::*;
#(
   parameter int SIZE_X    = 16,
   parameter int SIZE_Y    = 1,
   parameter int LABEL_LEN = 6,
   parameter logic [8*LABEL_LEN-1:0] LABEL = "SCORE:",
   parameter int SCORE_W   = 16,
   parameter int DIGITS    = 5,
   parameter int DIGIT_COL = 8,
   parameter bit BLANK_LZ  = 1'b1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        score_valid,
   input  logic [SCORE_W-1:0]          score,
   output logic                        score_ready,
   output logic                        update_done,
   input  logic [$clog2(SIZE_X+1)-1:0] char_x,
   input  logic [$clog2(SIZE_Y+1)-1:0] char_y,
   output logic [6:0]                  char_code
);
   localparam int XW = $clog2(SIZE_X+1);
   localparam int YW = $clog2(SIZE_Y+1);

   score_state_t        state;
   logic [DIGITS*4-1:0] shown;
   logic [DIGITS*4-1:0] conv_bcd;
   logic                conv_busy;
   logic                conv_done;
   logic                hs;

   assign score_ready = (state == IDLE) && !rst;
   assign hs          = score_valid && score_ready;

   bin2bcd_seq #(
      .SCORE_W (SCORE_W),
      .DIGITS  (DIGITS)
   ) u_conv (
      .clk    (clk),
      .rst    (rst),
      .start  (hs),
      .bin_in (score),
      .busy   (conv_busy),
      .done   (conv_done),
      .bcd    (conv_bcd)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         shown       <= '0;
         update_done <= 1'b0;
      end else begin
         update_done <= 1'b0;
         unique case (state)
            IDLE:
               if (hs) state <= CONVERT;
            CONVERT:
               if (conv_done)      state <= COMMIT;
               else if (!conv_busy) state <= IDLE;
            COMMIT: begin
               shown       <= conv_bcd;
               update_done <= 1'b1;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   logic              in_rng, is_lbl, is_dig, seen;
   logic [6:0]        lbl_chr, dig_chr, nxt;
   logic [DIGITS-1:0] lz;

   always_comb begin
      in_rng = (char_x < XW'(SIZE_X)) && (char_y < YW'(SIZE_Y));
      is_lbl = in_rng && (char_y == '0) && (char_x < XW'(LABEL_LEN));
      is_dig = in_rng && (char_y == '0)
               && (char_x >= XW'(DIGIT_COL))
               && (char_x < XW'(DIGIT_COL + DIGITS));

      lbl_chr = CHAR_SPACE;
      for (int k = 0; k < LABEL_LEN; k++) begin
         if (char_x == XW'(k))
            lbl_chr = LABEL[8*(LABEL_LEN-1-k) +: 7];
      end

      // digit 0 is the most significant; last digit never blanked
      seen = 1'b0;
      lz   = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (shown[4*(DIGITS-1-i) +: 4] != 4'd0) seen = 1'b1;
         lz[i] = BLANK_LZ && !seen && (i != DIGITS-1);
      end

      dig_chr = CHAR_SPACE;
      for (int i = 0; i < DIGITS; i++) begin
         if (char_x == XW'(DIGIT_COL + i))
            dig_chr = lz[i] ? CHAR_SPACE
                    : CHAR_ZERO + {3'b000, shown[4*(DIGITS-1-i) +: 4]};
      end

      unique case (1'b1)
         is_lbl:  nxt = lbl_chr;
         is_dig:  nxt = dig_chr;
         default: nxt = CHAR_SPACE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) char_code <= 7'h00;
      else     char_code <= nxt;
   end
endmodule

// File: tb/tb_score_char_buffer.sv
// Randomized scoreboard bench for score_char_buffer, blanked
// and unblanked builds side by side.
module tb_score_char_buffer;
   logic        clk = 1'b0;
   logic        rst;
   logic        score_valid;
   logic [15:0] score;
   logic [4:0]  char_x;
   logic [0:0]  char_y;
   logic        score_ready, update_done;
   logic [6:0]  char_code;
   logic        score_ready_nz, update_done_nz;
   logic [6:0]  char_code_nz;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   score_char_buffer u_dut (
      .clk         (clk),
      .rst         (rst),
      .score_valid (score_valid),
      .score       (score),
      .score_ready (score_ready),
      .update_done (update_done),
      .char_x      (char_x),
      .char_y      (char_y),
      .char_code   (char_code)
   );

   score_char_buffer #(.BLANK_LZ(1'b0)) u_dut_nz (
      .clk         (clk),
      .rst         (rst),
      .score_valid (score_valid),
      .score       (score),
      .score_ready (score_ready_nz),
      .update_done (update_done_nz),
      .char_x      (char_x),
      .char_y      (char_y),
      .char_code   (char_code_nz)
   );

   task automatic check(input string name, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s @%0t: got %h, expected %h", name, $time, got, exp);
      end
   endtask

   // text the score line should show for committed value v
   function automatic logic [6:0] exp_char(int x, int y, int v, bit blank);
      string lbl = "SCORE:";
      byte   b;
      int    i, p;
      if (x >= 16 || y >= 1) return 7'h20;
      if (x < 6) begin
         b = lbl[x];
         return b[6:0];
      end
      if (x >= 8 && x < 13) begin
         i = x - 8;
         p = 10 ** (4 - i);
         if (blank && i != 4 && v < p) return 7'h20;
         return 7'(8'h30 + (v / p) % 10);
      end
      return 7'h20;
   endfunction

   // reference model state
   int         cyc = 0;
   bit         busy_m = 0;
   int         shown_m = 0;
   int         pend_m, commit_cyc;
   int         acc_cnt = 0;
   logic [6:0] qc[$], qn[$];
   int         qd[$];

   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         busy_m  = 0;
         shown_m = 0;
         qc.push_back(7'h00);
         qn.push_back(7'h00);
      end else begin
         qc.push_back(exp_char(int'(char_x), int'(char_y), shown_m, 1'b1));
         qn.push_back(exp_char(int'(char_x), int'(char_y), shown_m, 1'b0));
         if (score_valid && !busy_m) begin
            busy_m     = 1;
            pend_m     = int'(score);
            commit_cyc = cyc + 17;
            acc_cnt++;
         end else if (busy_m && cyc == commit_cyc) begin
            busy_m  = 0;
            shown_m = pend_m;
            qd.push_back(cyc);
         end
      end
   end

   // monitor
   always @(posedge clk) begin
      logic [6:0] ec, en;
      bit         ed;
      #1;
      ec = qc.pop_front();
      en = qn.pop_front();
      check("char_code", 32'(char_code), 32'(ec));
      check("char_code_nz", 32'(char_code_nz), 32'(en));
      check("score_ready", 32'(score_ready), 32'(!rst && !busy_m));
      ed = (qd.size() > 0) && (qd[0] == cyc);
      if (ed) void'(qd.pop_front());
      check("update_done", 32'(update_done), 32'(ed));
      check("update_done_nz", 32'(update_done_nz), 32'(ed));
   end

   // read address driver: column sweep with random excursions
   initial begin
      int rx = 0;
      forever begin
         @(negedge clk);
         if ($urandom_range(0, 5) == 0) char_x = 5'($urandom_range(0, 31));
         else char_x = 5'(rx);
         char_y = ($urandom_range(0, 6) == 0) ? 1'b1 : 1'b0;
         rx = (rx == 17) ? 0 : rx + 1;
      end
   end

   task automatic send(input int v);
      int t = 0;
      int a0 = acc_cnt;
      score       = 16'(v);
      score_valid = 1'b1;
      while (acc_cnt == a0 && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (acc_cnt == a0) check("accept_timeout", 32'(0), 32'(1));
      score_valid = 1'b0;
   endtask

   task automatic wait_idle(input int extra);
      int t = 0;
      while (busy_m && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (busy_m) check("idle_timeout", 32'(0), 32'(1));
      repeat (extra) @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int vals[6] = '{0, 9, 10, 9999, 10000, 65535};
      rst = 1'b1;
      score_valid = 1'b0;
      score = '0;
      char_x = '0;
      char_y = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);

      send(1234);
      wait_idle(20);
      send(65535);
      send(0);
      wait_idle(20);
      send(7);
      wait_idle(3);
      send(42);
      wait_idle(20);

      send(999);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (30) @(negedge clk);

      foreach (vals[k]) begin
         send(vals[k]);
         wait_idle(18);
      end
      for (int n = 0; n < 25; n++) begin
         send(int'($urandom_range(0, 65535)));
         if ($urandom_range(0, 2) == 0) wait_idle(int'($urandom_range(0, 20)));
      end
      wait_idle(25);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
